// File: rtl/spi_regs_bridge.sv
// spi_regs_bridge: SPI mode-0 slave (MSB first) that turns microcontroller
// frames into single-beat register-file bus transactions.
//   clk, rstn          system clock, synchronous active-low reset
//   spiSclk/Csn/Mosi   asynchronous SPI pins, synchronised and oversampled
//   spiMiso, spiMisoOe serial read data and its output enable (CS low)
//   val/addr/write/wdata  bus request (val is a one-cycle pulse)
//   rdata/ready        bus response
//   busErr/errClr      sticky ready-timeout flag and its clear
// Frame: 16-bit header {W, 5 ignored, addr[9:0]}, then 32 write data bits,
// or 8 dummy bits followed by 32 read data bits on MISO.
module spi_regs_bridge #(
  parameter int unsigned TIMEOUT     = 15,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        spiSclk,
  input  logic        spiCsn,
  input  logic        spiMosi,
  output logic        spiMiso,
  output logic        spiMisoOe,
  output logic        val,
  output logic [9:0]  addr,
  output logic        write,
  output logic [31:0] wdata,
  input  logic [31:0] rdata,
  input  logic        ready,
  output logic        busErr,
  input  logic        errClr
);

  typedef enum logic [3:0] {
    IDLE, HDR, WDATA, WREQ, WWAIT, RREQ, RWAIT, RDUMMY, RDATA, DONE
  } state_t;

  localparam logic [7:0]  TMO_LAST = 8'(TIMEOUT - 1);
  localparam logic [31:0] BAD_DATA = 32'hDEAD_BEEF;

  state_t state, state_nxt;

  logic [SYNC_STAGES-1:0] sclk_sync, csn_sync, mosi_sync, vld_sync;
  logic sclk_s, csn_s, mosi_s, sync_vld, sclk_d;
  logic rise, fall, launch, timed_out, set_err, armed;
  logic [5:0]  bit_cnt;
  logic [7:0]  tcnt;
  logic [31:0] rx, tx;

  // vld_sync marks when the CS synchroniser holds a real pin sample rather
  // than its reset value, so a CS held low through reset cannot arm a frame.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      sclk_sync <= '0;
      csn_sync  <= '1;
      mosi_sync <= '0;
      vld_sync  <= '0;
      sclk_d    <= 1'b0;
    end else begin
      sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], spiSclk};
      csn_sync  <= {csn_sync[SYNC_STAGES-2:0], spiCsn};
      mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], spiMosi};
      vld_sync  <= {vld_sync[SYNC_STAGES-2:0], 1'b1};
      sclk_d    <= sclk_s;
    end
  end

  assign sclk_s    = sclk_sync[SYNC_STAGES-1];
  assign csn_s     = csn_sync[SYNC_STAGES-1];
  assign mosi_s    = mosi_sync[SYNC_STAGES-1];
  assign sync_vld  = vld_sync[SYNC_STAGES-1];
  assign spiMisoOe = ~csn_s;

  assign rise      = sclk_s & ~sclk_d;
  assign fall      = ~sclk_s & sclk_d;
  // Rises keep counting through RREQ/RWAIT, so the fall after the 8th rise
  // is recognised as the MISO launch edge even before RDUMMY is reached.
  assign launch    = fall && (bit_cnt == 6'd8);
  assign timed_out = (tcnt == TMO_LAST);

  always_ff @(posedge clk) begin
    if (!rstn) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    set_err   = 1'b0;
    val       = 1'b0;
    unique case (state)
      IDLE:   if (armed && !csn_s) state_nxt = HDR;
      HDR:    if (csn_s) state_nxt = IDLE;
              else if (rise && bit_cnt == 6'd15) state_nxt = rx[14] ? WDATA : RREQ;
      WDATA:  if (csn_s) state_nxt = IDLE;
              else if (rise && bit_cnt == 6'd31) state_nxt = WREQ;
      WREQ:   begin val = 1'b1; state_nxt = WWAIT; end
      WWAIT:  if (ready) state_nxt = DONE;
              else if (timed_out) begin set_err = 1'b1; state_nxt = DONE; end
      RREQ:   begin val = 1'b1; state_nxt = RWAIT; end
      RWAIT:  if (launch) begin set_err = 1'b1; state_nxt = RDATA; end
              else if (ready) state_nxt = RDUMMY;
              else if (timed_out) begin set_err = 1'b1; state_nxt = RDUMMY; end
      RDUMMY: if (csn_s) state_nxt = IDLE;
              else if (launch) state_nxt = RDATA;
      RDATA:  if (csn_s) state_nxt = IDLE;
              else if (rise && bit_cnt == 6'd31) state_nxt = DONE;
      DONE:   if (csn_s) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      armed   <= 1'b0;
      bit_cnt <= '0;
      tcnt    <= '0;
      rx      <= '0;
      tx      <= '0;
      addr    <= '0;
      write   <= 1'b0;
      wdata   <= '0;
      spiMiso <= 1'b0;
      busErr  <= 1'b0;
    end else begin
      // A frame may only start after CS has been seen high.
      if (sync_vld && csn_s)                      armed <= 1'b1;
      else if (state == IDLE && state_nxt == HDR) armed <= 1'b0;

      if (errClr)       busErr <= 1'b0;
      else if (set_err) busErr <= 1'b1;

      unique case (state)
        IDLE: bit_cnt <= '0;
        HDR, WDATA: if (rise) begin
          rx <= {rx[30:0], mosi_s};
          if (state == HDR && bit_cnt == 6'd15) begin
            addr    <= {rx[8:0], mosi_s};
            write   <= rx[14];
            bit_cnt <= '0;
          end else if (state == WDATA && bit_cnt == 6'd31) begin
            wdata   <= {rx[30:0], mosi_s};
            bit_cnt <= '0;
          end else begin
            bit_cnt <= bit_cnt + 6'd1;
          end
        end
        WREQ:  tcnt <= '0;
        WWAIT: tcnt <= tcnt + 8'd1;
        RREQ: begin
          tcnt <= '0;
          if (rise) bit_cnt <= bit_cnt + 6'd1;
        end
        RWAIT: begin
          tcnt <= tcnt + 8'd1;
          if (rise) bit_cnt <= bit_cnt + 6'd1;
          if (launch) begin
            tx      <= BAD_DATA;
            spiMiso <= BAD_DATA[31];
            bit_cnt <= '0;
          end else if (ready) begin
            tx <= rdata;
          end else if (timed_out) begin
            tx <= BAD_DATA;
          end
        end
        RDUMMY: begin
          if (rise) bit_cnt <= bit_cnt + 6'd1;
          if (launch) begin
            spiMiso <= tx[31];
            bit_cnt <= '0;
          end
        end
        RDATA: begin
          if (rise) begin
            bit_cnt <= bit_cnt + 6'd1;
            if (bit_cnt == 6'd31) spiMiso <= 1'b0;
          end else if (fall) begin
            tx      <= {tx[30:0], 1'b0};
            spiMiso <= tx[30];
          end
        end
        DONE: spiMiso <= 1'b0;
        default: ;
      endcase

      if (csn_s) spiMiso <= 1'b0;
    end
  end

endmodule
